// File: rtl/bcd_clock_hms.sv
// ---------------------------------------------------------------------------
// bcd_clock_hms
//
// BCD time-of-day counter with optional seconds, minutes and hours fields.
// Each field is held as two packed BCD digits. The internal state is always
// in 24-hour form (0..HOUR_MOD-1); the 12-hour view is a combinational
// remap on the hours byte of `out` only.
//
// Parameters:
//   SEC_EN   - 1 = hh:mm:ss, 0 = hh:mm
//   SUB_MOD  - modulus of seconds and minutes fields (2..100)
//   HOUR_MOD - modulus of hours field (2..100)
//   W        - derived output width (24 or 16), not overridable
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   tick      in   count enable, one advance per clk while high
//   mode12    in   12-hour display (only when HOUR_MOD == 24)
//   load      in   synchronous preset strobe (beats tick)
//   load_val  in   preset, 24-hour BCD, same layout as out
//   out       out  BCD time {hours, minutes[, seconds]}
//   pm        out  internal hour >= 12 while 12-hour display is active
//   min_wrap  out  registered pulse: minutes rolled to 00
//   hour_wrap out  registered pulse: hours rolled HOUR_MOD-1 -> 00
// ---------------------------------------------------------------------------
module bcd_clock_hms #(
    parameter  int SEC_EN   = 1,
    parameter  int SUB_MOD  = 60,
    parameter  int HOUR_MOD = 24,
    localparam int W        = (SEC_EN != 0) ? 24 : 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         mode12,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] out,
    output logic         pm,
    output logic         min_wrap,
    output logic         hour_wrap
);

    localparam int         HR_LSB    = W - 8;
    localparam int         MIN_LSB   = W - 16;
    localparam logic [6:0] SUB_LAST  = 7'(SUB_MOD - 1);
    localparam logic [6:0] HOUR_LAST = 7'(HOUR_MOD - 1);

    // Binary value of a BCD byte. Only meaningful for legal digits; callers
    // screen digits > 9 separately.
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] f);
        bcd_to_bin = ({3'b000, f[7:4]} * 7'd10) + {3'b000, f[3:0]};
    endfunction

    // Next value of a field on an advance; `last` means it sits at modulus-1.
    function automatic logic [7:0] bcd_inc(input logic [7:0] f, input logic last);
        if (last)
            bcd_inc = 8'h00;
        else if (f[3:0] == 4'd9)
            bcd_inc = {f[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = {f[7:4], f[3:0] + 4'd1};
    endfunction

    // Preset screening: a field with a non-decimal digit or a value outside
    // its modulus is replaced by 00; legal fields pass through untouched.
    function automatic logic [7:0] load_field(input logic [7:0] f, input logic [6:0] last);
        if ((f[7:4] > 4'd9) || (f[3:0] > 4'd9) || (bcd_to_bin(f) > last))
            load_field = 8'h00;
        else
            load_field = f;
    endfunction

    // 1..11 back to BCD.
    function automatic logic [7:0] small_to_bcd(input logic [6:0] v);
        if (v >= 7'd10)
            small_to_bcd = {4'h1, 4'(v - 7'd10)};
        else
            small_to_bcd = {4'h0, v[3:0]};
    endfunction

    logic [7:0] min_q;
    logic [7:0] hr_q;
    logic       sec_last;
    logic       min_last;
    logic       hr_last;
    logic       adv_min;
    logic       min_roll;
    logic       hr_roll;
    logic [7:0] hr_disp;
    logic [6:0] hr_bin;
    logic       mode12_eff;

    assign min_last = (bcd_to_bin(min_q) == SUB_LAST);
    assign hr_last  = (bcd_to_bin(hr_q) == HOUR_LAST);

    // Carry chain resolves within one cycle: a full seconds field advances
    // minutes, a full minutes field advances hours.
    assign adv_min  = tick & sec_last;
    assign min_roll = adv_min & min_last;
    assign hr_roll  = min_roll & hr_last;

    generate
        if (SEC_EN != 0) begin : g_sec
            logic [7:0] sec_q;

            assign sec_last = (bcd_to_bin(sec_q) == SUB_LAST);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    sec_q <= 8'h00;
                else if (load)
                    sec_q <= load_field(load_val[7:0], SUB_LAST);
                else if (tick)
                    sec_q <= bcd_inc(sec_q, sec_last);
            end

            assign out = {hr_disp, min_q, sec_q};
        end else begin : g_nosec
            // Without seconds every tick advances minutes directly.
            assign sec_last = 1'b1;
            assign out      = {hr_disp, min_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q     <= 8'h00;
            hr_q      <= 8'h00;
            min_wrap  <= 1'b0;
            hour_wrap <= 1'b0;
        end else if (load) begin
            min_q     <= load_field(load_val[MIN_LSB +: 8], SUB_LAST);
            hr_q      <= load_field(load_val[HR_LSB +: 8], HOUR_LAST);
            min_wrap  <= 1'b0;
            hour_wrap <= 1'b0;
        end else begin
            if (adv_min)
                min_q <= bcd_inc(min_q, min_last);
            if (min_roll)
                hr_q <= bcd_inc(hr_q, hr_last);
            min_wrap  <= min_roll;
            hour_wrap <= hr_roll;
        end
    end

    // 12-hour view only makes sense for a 24-hour day.
    assign mode12_eff = mode12 & (HOUR_MOD == 24);
    assign hr_bin     = bcd_to_bin(hr_q);

    always_comb begin
        hr_disp = hr_q;
        pm      = 1'b0;
        if (mode12_eff) begin
            pm = (hr_bin >= 7'd12);
            if (hr_bin == 7'd0)
                hr_disp = 8'h12;
            else if (hr_bin > 7'd12)
                hr_disp = small_to_bcd(hr_bin - 7'd12);
        end
    end

endmodule

// File: tb/tb_bcd_clock_hms.sv
module tb_bcd_clock_hms;

    logic        clk;
    logic        rst;

    logic        tick_a, mode12_a, load_a;
    logic [23:0] load_val_a, out_a;
    logic        pm_a, mw_a, hw_a;

    logic        tick_b, mode12_b, load_b;
    logic [15:0] load_val_b, out_b;
    logic        pm_b, mw_b, hw_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [23:0] exp;
    } sb_t;

    sb_t sb[$];

    bcd_clock_hms dut_a (
        .clk(clk), .rst(rst), .tick(tick_a), .mode12(mode12_a), .load(load_a),
        .load_val(load_val_a), .out(out_a), .pm(pm_a),
        .min_wrap(mw_a), .hour_wrap(hw_a)
    );

    bcd_clock_hms #(.SEC_EN(0), .SUB_MOD(60), .HOUR_MOD(12)) dut_b (
        .clk(clk), .rst(rst), .tick(tick_b), .mode12(mode12_b), .load(load_b),
        .load_val(load_val_b), .out(out_b), .pm(pm_b),
        .min_wrap(mw_b), .hour_wrap(hw_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] bcd2(input int v);
        bcd2 = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push(input string tag, input int kind, input logic [23:0] v);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic exp_a(input string tag, input logic [23:0] o, input logic p,
                         input logic mw, input logic hw);
        push({tag, "_out"}, 0, o);
        push({tag, "_pm"}, 1, {23'd0, p});
        push({tag, "_minwrap"}, 2, {23'd0, mw});
        push({tag, "_hourwrap"}, 3, {23'd0, hw});
    endtask

    task automatic exp_b(input string tag, input logic [15:0] o, input logic p,
                         input logic mw, input logic hw);
        push({tag, "_out"}, 4, {8'h00, o});
        push({tag, "_pm"}, 5, {23'd0, p});
        push({tag, "_minwrap"}, 6, {23'd0, mw});
        push({tag, "_hourwrap"}, 7, {23'd0, hw});
    endtask

    task automatic drain();
        sb_t         e;
        logic [23:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = out_a;
                1:       obs = {23'd0, pm_a};
                2:       obs = {23'd0, mw_a};
                3:       obs = {23'd0, hw_a};
                4:       obs = {8'h00, out_b};
                5:       obs = {23'd0, pm_b};
                6:       obs = {23'd0, mw_b};
                7:       obs = {23'd0, hw_b};
                default: obs = 24'hxxxxxx;
            endcase
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One clock edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a_val(input logic [23:0] v);
        load_a     = 1'b1;
        load_val_a = v;
        step();
        load_a     = 1'b0;
    endtask

    task automatic load_b_val(input logic [15:0] v);
        load_b     = 1'b1;
        load_val_b = v;
        step();
        load_b     = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        tick_a     = 1'b0; mode12_a = 1'b0; load_a = 1'b0; load_val_a = 24'h0;
        tick_b     = 1'b0; mode12_b = 1'b0; load_b = 1'b0; load_val_b = 16'h0;
        #1 rst = 1'b0;
        #1;
        exp_a("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
        exp_b("reset_b", 16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        mode12_a = 1'b1;
        #1;
        exp_a("reset_12h", 24'h120000, 1'b0, 1'b0, 1'b0);
        drain();
        mode12_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 60 ticks from zero: seconds run 00..59 then roll into minute 01.
        tick_a = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            push("tick_out", 0, {8'h00, bcd2(i / 60), bcd2(i % 60)});
            push("tick_minwrap", 2, 24'h0);
            drain();
        end
        tick_a = 1'b0;

        // Day rollover: both strobes for exactly one cycle.
        load_a_val(24'h235959);
        exp_a("pre_day", 24'h235959, 1'b0, 1'b0, 1'b0);
        drain();
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        exp_a("day_wrap", 24'h000000, 1'b0, 1'b1, 1'b1);
        drain();
        step();
        exp_a("day_wrap_clr", 24'h000000, 1'b0, 1'b0, 1'b0);
        drain();

        // Minute rollover without hour rollover.
        load_a_val(24'h105959);
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        exp_a("min_wrap", 24'h110000, 1'b0, 1'b1, 1'b0);
        drain();

        // Illegal field screening.
        load_a_val(24'h7A6099);
        exp_a("illegal_all", 24'h000000, 1'b0, 1'b0, 1'b0);
        drain();
        load_a_val(24'h12345A);
        exp_a("illegal_sec", 24'h123400, 1'b0, 1'b0, 1'b0);
        drain();
        load_a_val(24'h240000);
        exp_a("illegal_hr24", 24'h000000, 1'b0, 1'b0, 1'b0);
        drain();

        // 12-hour display.
        mode12_a = 1'b1;
        load_a_val(24'h000000);
        exp_a("m12_midnight", 24'h120000, 1'b0, 1'b0, 1'b0);
        drain();
        load_a_val(24'h120000);
        exp_a("m12_noon", 24'h120000, 1'b1, 1'b0, 1'b0);
        drain();
        load_a_val(24'h230000);
        exp_a("m12_23", 24'h110000, 1'b1, 1'b0, 1'b0);
        drain();
        load_a_val(24'h130500);
        exp_a("m12_13", 24'h010500, 1'b1, 1'b0, 1'b0);
        drain();
        mode12_a = 1'b0;
        #1;
        exp_a("m12_drop", 24'h130500, 1'b0, 1'b0, 1'b0);
        drain();

        // Load beats tick; no wrap strobes from a load.
        load_a_val(24'h105959);
        load_a     = 1'b1;
        tick_a     = 1'b1;
        load_val_a = 24'h000000;
        step();
        load_a = 1'b0;
        tick_a = 1'b0;
        exp_a("load_tick", 24'h000000, 1'b0, 1'b0, 1'b0);
        drain();

        // Hours:minutes variant with a 12-hour modulus.
        load_b_val(16'h1159);
        exp_b("b_pre", 16'h1159, 1'b0, 1'b0, 1'b0);
        drain();
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        exp_b("b_wrap", 16'h0000, 1'b0, 1'b1, 1'b1);
        drain();
        step();
        exp_b("b_wrap_clr", 16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        mode12_b = 1'b1;
        load_b_val(16'h1100);
        exp_b("b_m12_ignored", 16'h1100, 1'b0, 1'b0, 1'b0);
        drain();
        load_b_val(16'h1200);
        exp_b("b_illegal_hr", 16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        exp_b("b_tick", 16'h0001, 1'b0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of a tick burst.
        load_a_val(24'h000000);
        tick_a = 1'b1;
        step(); step(); step();
        exp_a("burst", 24'h000003, 1'b0, 1'b0, 1'b0);
        drain();
        #2 rst = 1'b0;
        #1;
        exp_a("async_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        exp_b("async_rst_b", 16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        step();
        tick_a = 1'b0;
        exp_a("post_rst", 24'h000001, 1'b0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_clock_hms.md
Name: bcd_clock_hms

Overview:
- Parametrised BCD time-of-day counter: seconds (optional), minutes and hours, two BCD digits per field.
- Successor to the fixed 24/60 hour-minute counter. Adds configurable moduli, an optional seconds stage, a count-enable tick, synchronous preset load, 12-hour display mode and registered wrap strobes.
- Sits between the 1 Hz tick divider and the seven-segment display driver.

Parameters:
- SEC_EN, 1, 1 = include seconds field; 0 = hours:minutes only.
- SUB_MOD, 60, modulus of the seconds and minutes fields; legal 2..100 (100 means 00..99).
- HOUR_MOD, 24, modulus of the hours field in 24-hour mode; legal 2..100.
- W (derived, not overridable), SEC_EN ? 24 : 16, output width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  count enable; one advance per clk cycle while high.
- mode12  in  1  1 = 12-hour display; honoured only when HOUR_MOD==24.
- load  in  1  synchronous preset strobe.
- load_val  in  W  preset, internal 24-hour BCD, same field layout as out.
- out  out  W  time in BCD. Fields: [W-1:W-8] hours, next byte minutes, [7:0] seconds when SEC_EN=1.
- pm  out  1  1 when internal hour >= 12 and 12-hour mode is active; otherwise 0.
- min_wrap  out  1  registered one-cycle pulse: minute field rolled to 00.
- hour_wrap  out  1  registered one-cycle pulse: hour field rolled over (day wrap).

Behaviour:
- Reset (rst=0, asynchronous):
  - all internal fields = 00; pm=0; min_wrap=0; hour_wrap=0.
  - In 12-hour mode the hours display is then 12 with pm=0.
- Internal state: three (or two) BCD fields, each two 4-bit digits, always held in 24-hour form (0..HOUR_MOD-1).
- Priority per clk edge: load > tick > hold.
- Load:
  - Each field is checked independently. A field is illegal if either digit > 9 or the field value >= its modulus. An illegal field loads 00; a legal field loads verbatim.
  - Load never produces wrap pulses.
  - Load with tick=1 in the same cycle: the load wins and no advance occurs that cycle.
- Tick advance, in the least-significant field (seconds, or minutes when SEC_EN=0):
  - Low digit 9 -> 0 with tens +1.
  - Field == modulus-1 -> 00 and carry into the next field.
  - Carry ripples in the same cycle: seconds 59 -> minutes +1, minutes at SUB_MOD-1 -> hours +1, hours at HOUR_MOD-1 -> 00.
  - Fields with no carry hold.
- Wrap strobes are registered and high for exactly the cycle after the edge that performed the rollover:
  - min_wrap = minutes rolled to 00 on that edge.
  - hour_wrap = hours rolled HOUR_MOD-1 -> 00 on that edge.
  - Both pulse together at a day rollover.
  - Both are cleared next cycle unless a new wrap occurs; back-to-back wraps are only possible with small moduli.
- Display conversion (combinational, on out hours only) when mode12=1 and HOUR_MOD==24:
  - Internal 00 -> 12, 01..11 -> same, 12 -> 12, 13..23 -> 01..11.
  - pm = (internal >= 12).
  - Switching mode12 changes out and pm immediately, with no state change.
- When HOUR_MOD != 24: mode12 is ignored, out hours = internal, pm = 0.
- Reset asserted mid-count clears everything immediately. Release is synchronised by the environment; the first tick after release advances from 00.
- No X propagation: every register has a reset value; out is defined in every cycle.

Test Plan:
- Reset, then 60 ticks (SEC_EN=1, defaults) -> out=0x000100; min_wrap=0 throughout; seconds roll 0x59 -> 0x00 with minutes 0x00 -> 0x01.
- Load 0x235959, tick one cycle -> out=0x000000; next cycle min_wrap=1 and hour_wrap=1; both 0 the cycle after.
- Load 0x7A6099 -> all fields illegal -> out=0x000000. Load 0x12345A -> out=0x123400.
- mode12=1, load 0x000000 -> out hours 0x12, pm=0. Load 0x130500 -> out=0x010500, pm=1. Drop mode12 -> out=0x130500, pm=0, same cycle.
- SEC_EN=0, SUB_MOD=60, HOUR_MOD=12: load 0x1159, tick -> out=0x0000, hour_wrap pulse. mode12=1 -> no conversion, pm=0.
- load=1 and tick=1 together with load_val=0x000000 from state 0x105959 -> out=0x000000, no wrap pulses. Assert rst mid-tick burst -> out=0 asynchronously, before the next edge.
